// File: rtl/bitlet_essential_bit_scanner.sv
// Bitlet essential-bit scanner: accepts a W-bit word and emits one beat per
// set bit, LSB-first, with index/last/zero/popcount; valid/ready both sides.
module bitlet_essential_bit_scanner #(
  parameter  int W  = 16,
  localparam int IW = $clog2(W)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VLD,
  output logic          IN_RDY,
  input  logic [W-1:0]  IN_DATA,
  output logic          OUT_VLD,
  input  logic          OUT_RDY,
  output logic [IW-1:0] OUT_IDX,
  output logic          OUT_LAST,
  output logic          OUT_ZERO,
  output logic [IW:0]   OUT_NUM
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [IW:0]   num_q, num_d;
  logic          zero_q, zero_d;

  logic [IW:0]   pop;
  logic [IW-1:0] low_idx;
  logic          at_most_one;
  logic          in_xfer;
  logic          out_xfer;

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + (IW+1)'(IN_DATA[i]);
    end
  end

  // Scan downward so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = W-1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = IW'(i);
    end
  end

  // x & (x-1) clears the lowest set bit; zero result => at most one bit.
  assign at_most_one = (mask_q & (mask_q - W'(1))) == '0;

  assign OUT_VLD  = (state_q == SCAN);
  assign OUT_IDX  = low_idx;
  assign OUT_LAST = at_most_one;
  assign OUT_ZERO = zero_q;
  assign OUT_NUM  = num_q;

  assign out_xfer = OUT_VLD && OUT_RDY;
  assign IN_RDY   = (state_q == IDLE) || (out_xfer && OUT_LAST);
  assign in_xfer  = IN_VLD && IN_RDY;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    num_d   = num_q;
    zero_d  = zero_q;
    if (in_xfer) begin
      mask_d  = IN_DATA;
      num_d   = pop;
      zero_d  = (IN_DATA == '0);
      state_d = SCAN;
    end else if (out_xfer) begin
      if (OUT_LAST) begin
        mask_d  = '0;
        state_d = IDLE;
      end else begin
        mask_d  = mask_q & (mask_q - W'(1));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      mask_q  <= '0;
      num_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_bitlet_essential_bit_scanner.sv
// Bench for bitlet_essential_bit_scanner: directed scenarios plus random
// traffic, with a beat scoreboard fed on input transfers.
module tb_bitlet_essential_bit_scanner;

  localparam int W  = 16;
  localparam int IW = 4;

  logic          CLK;
  logic          RST_N;
  logic          IN_VLD;
  logic          IN_RDY;
  logic [W-1:0]  IN_DATA;
  logic          OUT_VLD;
  logic          OUT_RDY;
  logic [IW-1:0] OUT_IDX;
  logic          OUT_LAST;
  logic          OUT_ZERO;
  logic [IW:0]   OUT_NUM;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [IW-1:0] idx;
    logic          last;
    logic          zero;
    logic [IW:0]   num;
    logic [W-1:0]  word;
  } beat_t;

  beat_t        sb[$];
  beat_t        mon_e;
  logic [W-1:0] acc;
  int           beats;

  bitlet_essential_bit_scanner #(.W(W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VLD   (IN_VLD),
    .IN_RDY   (IN_RDY),
    .IN_DATA  (IN_DATA),
    .OUT_VLD  (OUT_VLD),
    .OUT_RDY  (OUT_RDY),
    .OUT_IDX  (OUT_IDX),
    .OUT_LAST (OUT_LAST),
    .OUT_ZERO (OUT_ZERO),
    .OUT_NUM  (OUT_NUM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void push_word(input logic [W-1:0] d);
    beat_t b;
    int n;
    int k;
    n = 0;
    for (int i = 0; i < W; i++) if (d[i]) n++;
    if (d == '0) begin
      b.idx = '0; b.last = 1'b1; b.zero = 1'b1;
      b.num = '0; b.word = d;
      sb.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < W; i++) begin
        if (d[i]) begin
          k++;
          b.idx  = IW'(i);
          b.last = (k == n);
          b.zero = 1'b0;
          b.num  = (IW+1)'(n);
          b.word = d;
          sb.push_back(b);
        end
      end
    end
  endfunction

  // Scoreboard monitor: samples 2 time units before each rising edge.
  always begin
    @(negedge CLK);
    #3;
    if (RST_N && OUT_VLD && OUT_RDY) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got beat idx %0d, want none",
                 OUT_IDX);
      end else begin
        mon_e = sb.pop_front();
        if (OUT_IDX !== mon_e.idx || OUT_LAST !== mon_e.last ||
            OUT_ZERO !== mon_e.zero || OUT_NUM !== mon_e.num)
          $display("FAIL sb_beat: got idx=%0d last=%0b zero=%0b num=%0d, want idx=%0d last=%0b zero=%0b num=%0d",
                   OUT_IDX, OUT_LAST, OUT_ZERO, OUT_NUM,
                   mon_e.idx, mon_e.last, mon_e.zero, mon_e.num);
        else n_pass++;
        if (!OUT_ZERO) acc = acc | (W'(1) << OUT_IDX);
        beats++;
        if (mon_e.last) begin
          n_checks++;
          if (acc !== mon_e.word ||
              beats != (mon_e.zero ? 1 : int'(mon_e.num)))
            $display("FAIL sb_word: got or=%h beats=%0d, want or=%h num=%0d",
                     acc, beats, mon_e.word, mon_e.num);
          else n_pass++;
          acc   = '0;
          beats = 0;
        end
      end
    end
    if (RST_N && IN_VLD && IN_RDY) push_word(IN_DATA);
  end

  task automatic send_word(input logic [W-1:0] d, output int waits);
    waits = 0;
    @(negedge CLK);
    IN_VLD  = 1'b1;
    IN_DATA = d;
    #1;
    while (!IN_RDY && waits < 100) begin
      @(negedge CLK);
      #1;
      waits++;
    end
    if (waits >= 100) begin
      n_checks++;
      $display("FAIL send_timeout: got IN_RDY=0 after %0d cycles, want 1",
               waits);
    end
    @(posedge CLK);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      IN_VLD  = 1'b0;
      OUT_RDY = 1'b1;
      #4;
      if (sb.size() == 0 && !OUT_VLD) done = 1'b1;
    end
    n_checks++;
    if (!done)
      $display("FAIL drain: got %0d beats pending, want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({OUT_VLD, IN_RDY, OUT_IDX, OUT_LAST, OUT_ZERO, OUT_NUM} !==
        {1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 5'd0})
      $display("FAIL reset: got vld=%0b rdy=%0b idx=%0d last=%0b zero=%0b num=%0d, want 0 1 0 1 0 0",
               OUT_VLD, IN_RDY, OUT_IDX, OUT_LAST, OUT_ZERO, OUT_NUM);
    else n_pass++;
    #5;
    RST_N = 1'b1;
  endtask

  task automatic test_8421();
    int w;
    OUT_RDY = 1'b1;
    send_word(16'h8421, w);
    @(negedge CLK);
    IN_VLD  = 1'b0;
    IN_DATA = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      n_checks++;
      if (OUT_VLD !== 1'b1)
        $display("FAIL 8421_vld: beat %0d got vld=%0b, want 1", i, OUT_VLD);
      else n_pass++;
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if (OUT_VLD !== 1'b0 || IN_RDY !== 1'b1)
      $display("FAIL 8421_idle: got vld=%0b rdy=%0b, want 0 1",
               OUT_VLD, IN_RDY);
    else n_pass++;
  endtask

  task automatic test_zero();
    int w;
    OUT_RDY = 1'b1;
    send_word(16'h0000, w);
    @(negedge CLK);
    IN_VLD = 1'b0;
    #1;
    n_checks++;
    if ({OUT_VLD, OUT_ZERO, OUT_IDX, OUT_LAST, OUT_NUM} !==
        {1'b1, 1'b1, 4'd0, 1'b1, 5'd0})
      $display("FAIL zero_beat: got vld=%0b zero=%0b idx=%0d last=%0b num=%0d, want 1 1 0 1 0",
               OUT_VLD, OUT_ZERO, OUT_IDX, OUT_LAST, OUT_NUM);
    else n_pass++;
    @(negedge CLK);
    #1;
    n_checks++;
    if (OUT_VLD !== 1'b0 || IN_RDY !== 1'b1)
      $display("FAIL zero_idle: got vld=%0b rdy=%0b, want 0 1",
               OUT_VLD, IN_RDY);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w;
    OUT_RDY = 1'b1;
    send_word(16'h0003, w);
    send_word(16'h0100, w);
    n_checks++;
    if (w != 1)
      $display("FAIL b2b_rdy: got accept after %0d waits, want 1", w);
    else n_pass++;
    @(negedge CLK);
    IN_VLD = 1'b0;
    #1;
    n_checks++;
    if (OUT_VLD !== 1'b1 || OUT_IDX !== 4'd8)
      $display("FAIL b2b_bubble: got vld=%0b idx=%0d, want 1 8",
               OUT_VLD, OUT_IDX);
    else n_pass++;
    drain();
  endtask

  task automatic test_stall();
    int w;
    OUT_RDY = 1'b1;
    send_word(16'h00F0, w);
    @(negedge CLK);
    IN_VLD  = 1'b0;
    IN_DATA = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      OUT_RDY = 1'b0;
      IN_DATA = W'($urandom);
      #1;
      n_checks++;
      if ({OUT_VLD, IN_RDY, OUT_IDX, OUT_LAST, OUT_NUM} !==
          {1'b1, 1'b0, 4'd5, 1'b0, 5'd4})
        $display("FAIL stall_hold: cycle %0d got vld=%0b rdy=%0b idx=%0d last=%0b num=%0d, want 1 0 5 0 4",
                 i, OUT_VLD, IN_RDY, OUT_IDX, OUT_LAST, OUT_NUM);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_all_ones();
    int w;
    OUT_RDY = 1'b1;
    send_word(16'hFFFF, w);
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    OUT_RDY = 1'b1;
    send_word(16'hFFFF, w);
    @(negedge CLK);
    IN_VLD = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    sb.delete();
    acc   = '0;
    beats = 0;
    #1;
    n_checks++;
    if ({OUT_VLD, IN_RDY, OUT_IDX, OUT_LAST, OUT_ZERO, OUT_NUM} !==
        {1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 5'd0})
      $display("FAIL mid_reset: got vld=%0b rdy=%0b idx=%0d last=%0b zero=%0b num=%0d, want 0 1 0 1 0 0",
               OUT_VLD, IN_RDY, OUT_IDX, OUT_LAST, OUT_ZERO, OUT_NUM);
    else n_pass++;
    RST_N = 1'b1;
    #2;
    n_checks++;
    if (OUT_VLD !== 1'b0)
      $display("FAIL mid_stale: got vld=%0b after reset, want 0", OUT_VLD);
    else n_pass++;
    send_word(16'h0002, w);
    n_checks++;
    if (w != 0)
      $display("FAIL mid_first_edge: got %0d waits, want 0", w);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    bit hold;
    int r;
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      OUT_RDY = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        IN_VLD = $urandom_range(0, 1) == 1;
        r = $urandom_range(0, 7);
        if (r == 0)      IN_DATA = '0;
        else if (r == 1) IN_DATA = '1;
        else             IN_DATA = W'($urandom);
      end
      #1;
      hold = IN_VLD && !IN_RDY;
    end
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    acc      = '0;
    beats    = 0;
    RST_N    = 1'b0;
    IN_VLD   = 1'b0;
    IN_DATA  = '0;
    OUT_RDY  = 1'b0;
    test_reset();
    test_8421();
    test_zero();
    test_back_to_back();
    test_stall();
    test_all_ones();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
